tomasulo_rob: RTL and testbench

// Parametrised reorder buffer for the Tomasulo core. Sits between issue and the register bank.

---
 rtl/tomasulo_rob_if.sv | 50 +++++
 rtl/tomasulo_rob.sv | 162 ++++++++++++++++
 tb/tb_tomasulo_rob.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_rob_if.sv
// rtl/tomasulo_rob_if.sv - issue/writeback/lookup/commit bus of the Tomasulo reorder buffer
//
// Groups every ROB signal except clock and reset.
//   master : issue stage, CDB, register bank side (drives alloc_*, wb_*, lk_tag, commit_ready)
//   slave  : the reorder buffer (drives alloc_ready/tag, lk_*, commit_*, flush, count)
interface tomasulo_rob_if #(
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 16,
    parameter int REG_W     = 4,
    parameter int CDB_PORTS = 2
);
    logic                          alloc_valid;
    logic                          alloc_ready;
    logic [3:0]                    alloc_func;
    logic [REG_W-1:0]              alloc_rd;
    logic [TAG_W-1:0]              alloc_tag;
    logic [CDB_PORTS-1:0]          wb_valid;
    logic [CDB_PORTS*TAG_W-1:0]    wb_tag;
    logic [CDB_PORTS*DATA_W-1:0]   wb_data;
    logic [CDB_PORTS-1:0]          wb_mispred;
    logic [2*TAG_W-1:0]            lk_tag;
    logic [1:0]                    lk_ready;
    logic [2*DATA_W-1:0]           lk_data;
    logic                          commit_valid;
    logic                          commit_ready;
    logic [TAG_W-1:0]              commit_tag;
    logic [REG_W-1:0]              commit_rd;
    logic                          commit_we;
    logic [DATA_W-1:0]             commit_data;
    logic                          flush;
    logic [TAG_W:0]                count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output wb_valid, wb_tag, wb_data, wb_mispred,
        output lk_tag, commit_ready,
        input  alloc_ready, alloc_tag, lk_ready, lk_data,
        input  commit_valid, commit_tag, commit_rd, commit_we, commit_data,
        input  flush, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  wb_valid, wb_tag, wb_data, wb_mispred,
        input  lk_tag, commit_ready,
        output alloc_ready, alloc_tag, lk_ready, lk_data,
        output commit_valid, commit_tag, commit_rd, commit_we, commit_data,
        output flush, count
    );
endinterface

// File: rtl/tomasulo_rob.sv
// rtl/tomasulo_rob.sv - in-order-commit reorder buffer with CDB writeback and operand lookup
//
// Ports:
//   clk1 : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : tomasulo_rob_if.slave
//          alloc_*  allocate one entry per issued instruction, tag = tail pointer
//          wb_*     CDB_PORTS writeback ports (data, done, mispredict flag by tag)
//          lk_*     two combinational operand lookups by tag, with same-cycle CDB bypass
//          commit_* in-order retirement of the head entry
//          flush    one-cycle pulse after a mispredicted branch retires
//          count    occupied entries
module tomasulo_rob #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 16,
    parameter int REG_W     = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic           clk1,
    input  logic           rst,
    tomasulo_rob_if.slave  bus
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]   e_valid;
    logic [DEPTH-1:0]   e_done;
    logic [DEPTH-1:0]   e_mispred;
    logic [3:0]         e_func [DEPTH];
    logic [REG_W-1:0]   e_rd   [DEPTH];
    logic [DATA_W-1:0]  e_data [DEPTH];

    logic [TAG_W-1:0]   head;
    logic [TAG_W-1:0]   tail;
    logic [TAG_W:0]     cnt;
    logic               flush_q;
    logic               flush_pending;

    logic               do_alloc;
    logic               do_commit;

    logic [DEPTH-1:0]   wb_hit;
    logic [DEPTH-1:0]   wb_take;
    logic [DEPTH-1:0]   wb_sel_mp;
    logic [DATA_W-1:0]  wb_sel_data [DEPTH];

    logic [TAG_W-1:0]   lk_t [2];
    logic [1:0]         lk_ready_c;
    logic [2*DATA_W-1:0] lk_data_c;

    // Per-entry writeback select. Ports are scanned from the highest index
    // down so the lowest-numbered matching port is the last one to assign.
    always_comb begin
        wb_hit    = '0;
        wb_sel_mp = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wb_sel_data[e] = '0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.wb_valid[p] && (bus.wb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    wb_hit[e]      = 1'b1;
                    wb_sel_data[e] = bus.wb_data[p*DATA_W +: DATA_W];
                    wb_sel_mp[e]   = bus.wb_mispred[p];
                end
            end
        end
        // Only a live, still-pending entry accepts a result; this also
        // ignores a tag whose allocation happens in this same cycle.
        wb_take = wb_hit & e_valid & ~e_done;
    end

    // Operand lookup: stored result first, else bypass from this cycle's CDB.
    always_comb begin
        lk_ready_c = '0;
        lk_data_c  = '0;
        for (int i = 0; i < 2; i++) begin
            lk_t[i] = bus.lk_tag[i*TAG_W +: TAG_W];
            if (e_valid[lk_t[i]] && e_done[lk_t[i]]) begin
                lk_ready_c[i]                = 1'b1;
                lk_data_c[i*DATA_W +: DATA_W] = e_data[lk_t[i]];
            end else if (wb_take[lk_t[i]]) begin
                lk_ready_c[i]                = 1'b1;
                lk_data_c[i*DATA_W +: DATA_W] = wb_sel_data[lk_t[i]];
            end
        end
    end

    assign bus.alloc_ready  = (cnt != FULL) & ~flush_q & ~flush_pending;
    assign bus.alloc_tag    = tail;
    // Entries younger than a retired mispredicted branch are still present
    // while flush_pending is set; they must not retire before the clear.
    assign bus.commit_valid = e_valid[head] & e_done[head] & ~flush_q & ~flush_pending;
    assign bus.commit_tag   = head;
    assign bus.commit_rd    = e_rd[head];
    assign bus.commit_data  = e_data[head];
    assign bus.commit_we    = ~(e_func[head] inside {4'b0101, 4'b0110, 4'b0111});
    assign bus.lk_ready     = lk_ready_c;
    assign bus.lk_data      = lk_data_c;
    assign bus.flush        = flush_q;
    assign bus.count        = cnt;

    assign do_alloc  = bus.alloc_valid & bus.alloc_ready;
    assign do_commit = bus.commit_valid & bus.commit_ready;

    always_ff @(posedge clk1) begin
        if (rst) begin
            flush_pending <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            flush_pending <= do_commit & e_mispred[head];
            flush_q       <= flush_pending;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst || flush_pending) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            e_valid   <= '0;
            e_done    <= '0;
            e_mispred <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                e_func[e] <= '0;
                e_rd[e]   <= '0;
                e_data[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_take[e]) begin
                    e_done[e]    <= 1'b1;
                    e_mispred[e] <= wb_sel_mp[e];
                    e_data[e]    <= wb_sel_data[e];
                end
            end
            // Head is always done when committing and tail is never valid when
            // allocating, so these cannot collide with a writeback or each other.
            if (do_commit) begin
                e_valid[head]   <= 1'b0;
                e_done[head]    <= 1'b0;
                e_mispred[head] <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            if (do_alloc) begin
                e_valid[tail]   <= 1'b1;
                e_done[tail]    <= 1'b0;
                e_mispred[tail] <= 1'b0;
                e_func[tail]    <= bus.alloc_func;
                e_rd[tail]      <= bus.alloc_rd;
                tail            <= tail + TAG_W'(1);
            end
            case ({do_alloc, do_commit})
                2'b10:   cnt <= cnt + (TAG_W+1)'(1);
                2'b01:   cnt <= cnt - (TAG_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_tomasulo_rob.sv
// tb/tb_tomasulo_rob.sv - scoreboard bench for tomasulo_rob with program-order queue model
module tb_tomasulo_rob;

    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  func;
        logic [3:0]  rd;
        bit          done;
        bit          mp;
        logic [15:0] data;
    } ent_t;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    tomasulo_rob_if #(.TAG_W(3), .DATA_W(16), .REG_W(4), .CDB_PORTS(2)) bus();

    tomasulo_rob #(.DEPTH(8), .TAG_W(3), .DATA_W(16), .REG_W(4), .CDB_PORTS(2)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    ent_t       mq[$];
    logic [2:0] next_tag = 3'd0;
    int         flush_wait = 0;
    ent_t       mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int find(input logic [2:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic void lk_model(input logic [2:0] t, input logic [1:0] wv, input logic [5:0] wt,
                                     input logic [31:0] wd, output bit r, output logic [15:0] d);
        int k;
        r = 1'b0;
        d = 16'h0;
        k = find(t);
        if (k < 0) return;
        if (mq[k].done) begin
            r = 1'b1;
            d = mq[k].data;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (wv[p] && wt[p*3 +: 3] == t) begin
                r = 1'b1;
                d = wd[p*16 +: 16];
                return;
            end
        end
    endfunction

    // One clock cycle: drive, check state-derived outputs against the model,
    // then apply what the coming edge does to the model.
    task automatic cyc(input bit av, input logic [3:0] fn, input logic [3:0] rd,
                       input logic [1:0] wv, input logic [5:0] wt, input logic [31:0] wd,
                       input logic [1:0] wm, input logic [5:0] lt, input bit cr);
        bit          exp_ar, exp_cv, er;
        logic [15:0] ed;
        ent_t        e;
        int          k;
        @(posedge clk1);
        #1;
        bus.alloc_valid  = av;
        bus.alloc_func   = fn;
        bus.alloc_rd     = rd;
        bus.wb_valid     = wv;
        bus.wb_tag       = wt;
        bus.wb_data      = wd;
        bus.wb_mispred   = wm;
        bus.lk_tag       = lt;
        bus.commit_ready = cr;
        #1;
        exp_ar = (mq.size() != DEPTH) && (flush_wait == 0);
        exp_cv = (flush_wait == 0) && (mq.size() > 0) && mq[0].done;
        chk("alloc_ready", bus.alloc_ready, exp_ar);
        chk("commit_valid", bus.commit_valid, exp_cv);
        chk("flush", bus.flush, flush_wait == 1);
        if (flush_wait == 0) begin
            chk("count", bus.count, mq.size());
            chk("alloc_tag", bus.alloc_tag, next_tag);
            for (int i = 0; i < 2; i++) begin
                lk_model(lt[i*3 +: 3], wv, wt, wd, er, ed);
                chk("lk_ready", bus.lk_ready[i], er);
                chk("lk_data", bus.lk_data[i*16 +: 16], ed);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (wv[p]) begin
                k = find(wt[p*3 +: 3]);
                if (k >= 0 && !mq[k].done) begin
                    e      = mq[k];
                    e.done = 1'b1;
                    e.data = wd[p*16 +: 16];
                    e.mp   = wm[p];
                    mq[k]  = e;
                end
            end
        end
        if (av && exp_ar) begin
            e.tag = next_tag; e.func = fn; e.rd = rd; e.done = 1'b0; e.mp = 1'b0; e.data = 16'h0;
            mq.push_back(e);
            next_tag = next_tag + 3'd1;
        end
        if (flush_wait > 0) flush_wait--;
    endtask

    task automatic idle(input bit cr);
        cyc(1'b0, 4'h0, 4'h0, 2'b00, 6'h0, 32'h0, 2'b00, 6'h0, cr);
    endtask

    task automatic alloc(input logic [3:0] fn, input logic [3:0] rd);
        cyc(1'b1, fn, rd, 2'b00, 6'h0, 32'h0, 2'b00, 6'h0, 1'b0);
    endtask

    task automatic wb1(input logic [2:0] t, input logic [15:0] d, input bit mp, input bit cr);
        cyc(1'b0, 4'h0, 4'h0, 2'b01, {3'd0, t}, {16'h0, d}, {1'b0, mp}, 6'h0, cr);
    endtask

    task automatic do_reset(input bit wb_act);
        @(posedge clk1);
        #1;
        rst              = 1'b1;
        bus.alloc_valid  = 1'b0;
        bus.alloc_func   = 4'h0;
        bus.alloc_rd     = 4'h0;
        bus.wb_valid     = wb_act ? 2'b11 : 2'b00;
        bus.wb_tag       = 6'b001_000;
        bus.wb_data      = 32'h1234_5678;
        bus.wb_mispred   = 2'b00;
        bus.lk_tag       = 6'h0;
        bus.commit_ready = 1'b1;
        @(posedge clk1);
        #1;
        rst              = 1'b0;
        bus.wb_valid     = 2'b00;
        bus.commit_ready = 1'b0;
        mq.delete();
        next_tag   = 3'd0;
        flush_wait = 0;
        #1;
        chk("reset_count", bus.count, 0);
        chk("reset_commit_valid", bus.commit_valid, 0);
        chk("reset_alloc_tag", bus.alloc_tag, 0);
        chk("reset_alloc_ready", bus.alloc_ready, 1);
        chk("reset_lk_ready", bus.lk_ready, 0);
        chk("reset_flush", bus.flush, 0);
    endtask

    // Commit monitor: every retirement must match the oldest model entry.
    always @(negedge clk1) begin
        if (!rst && bus.commit_valid === 1'b1 && bus.commit_ready === 1'b1) begin
            if (mq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL commit_unexpected: actual commit of tag %0h required none", bus.commit_tag);
            end else begin
                mon_e = mq.pop_front();
                chk("commit_tag", bus.commit_tag, mon_e.tag);
                chk("commit_rd", bus.commit_rd, mon_e.rd);
                chk("commit_data", bus.commit_data, mon_e.data);
                chk("commit_we", bus.commit_we, !(mon_e.func inside {4'd5, 4'd6, 4'd7}));
                if (mon_e.mp) begin
                    mq.delete();
                    next_tag   = 3'd0;
                    flush_wait = 2;
                end
            end
        end
    end

    logic [1:0]  r_wv, r_wm;
    logic [5:0]  r_wt, r_lt;
    logic [31:0] r_wd;
    logic [2:0]  r_t;
    int          r_cnt;

    initial begin
        do_reset(1'b0);
        idle(1'b0);

        // three allocs, out-of-order writeback, in-order commit
        alloc(4'h0, 4'd1);
        alloc(4'h1, 4'd2);
        alloc(4'h2, 4'd3);
        idle(1'b0);
        chk("three_alloc_count", bus.count, 3);
        chk("three_alloc_commit_valid", bus.commit_valid, 0);
        wb1(3'd1, 16'h0005, 1'b0, 1'b1);
        wb1(3'd0, 16'h0007, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("after_two_commits_count", bus.count, 1);

        // fill, then commit one with alloc held: wrap to tag 0
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) alloc(4'h0, 4'(i));
        cyc(1'b1, 4'h3, 4'd9, 2'b01, 6'd0, 32'h0000_0042, 2'b00, 6'h0, 1'b0);
        chk("full_alloc_ready", bus.alloc_ready, 0);
        cyc(1'b1, 4'h3, 4'd9, 2'b00, 6'd0, 32'h0, 2'b00, 6'h0, 1'b1);
        cyc(1'b1, 4'h3, 4'd9, 2'b00, 6'd0, 32'h0, 2'b00, 6'h0, 1'b0);
        chk("wrap_alloc_tag", bus.alloc_tag, 0);
        chk("wrap_alloc_ready", bus.alloc_ready, 1);

        // dual-port writeback to the same tag: port 0 wins, bypass lookup sees it
        cyc(1'b0, 4'h0, 4'h0, 2'b11, {3'd4, 3'd4}, {16'h00BB, 16'h00AA}, 2'b00, {3'd4, 3'd4}, 1'b0);
        chk("dual_wb_lk_ready", bus.lk_ready[0], 1);
        chk("dual_wb_lk_data", bus.lk_data[15:0], 16'h00AA);
        cyc(1'b0, 4'h0, 4'h0, 2'b00, 6'h0, 32'h0, 2'b00, {3'd4, 3'd4}, 1'b0);
        chk("dual_wb_stored", bus.lk_data[31:16], 16'h00AA);

        // mispredicted beq at tag 2 with younger entries already done
        do_reset(1'b0);
        alloc(4'h0, 4'd1);
        alloc(4'h1, 4'd2);
        alloc(4'h5, 4'd0);
        alloc(4'h0, 4'd4);
        alloc(4'h1, 4'd5);
        cyc(1'b0, 4'h0, 4'h0, 2'b11, {3'd1, 3'd0}, {16'h0011, 16'h0010}, 2'b00, 6'h0, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 2'b11, {3'd4, 3'd3}, {16'h0014, 16'h0013}, 2'b00, 6'h0, 1'b0);
        wb1(3'd2, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("post_flush_count", bus.count, 0);
        chk("post_flush_alloc_tag", bus.alloc_tag, 0);
        alloc(4'h0, 4'd7);

        // reset with live entries and writebacks in the reset cycle
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) alloc(4'h0, 4'(i + 1));
        do_reset(1'b1);
        idle(1'b1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    r_t = mq[$urandom_range(0, mq.size() - 1)].tag;
                else
                    r_t = 3'($urandom_range(0, 7));
                r_wt[p*3 +: 3]  = r_t;
                r_wv[p]         = ($urandom_range(0, 2) != 0);
                r_wd[p*16 +: 16] = 16'($urandom);
                r_wm[p]         = ($urandom_range(0, 19) == 0);
                if (mq.size() > 0 && $urandom_range(0, 1) != 0)
                    r_t = mq[$urandom_range(0, mq.size() - 1)].tag;
                else
                    r_t = 3'($urandom_range(0, 7));
                r_lt[p*3 +: 3] = r_t;
            end
            if ($urandom_range(0, 7) == 0) r_wt[5:3] = r_wt[2:0];
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 4'($urandom),
                r_wv, r_wt, r_wd, r_wm, r_lt, $urandom_range(0, 3) != 0);
        end

        // drain: complete every pending entry and let it all retire
        for (int n = 0; n < 300 && (mq.size() > 0 || flush_wait > 0); n++) begin
            r_wv  = 2'b00;
            r_wt  = 6'h0;
            r_cnt = 0;
            foreach (mq[i]) begin
                if (!mq[i].done && r_cnt < 2) begin
                    r_wv[r_cnt]         = 1'b1;
                    r_wt[r_cnt*3 +: 3]  = mq[i].tag;
                    r_cnt++;
                end
            end
            cyc(1'b0, 4'h0, 4'h0, r_wv, r_wt, 32'h00C3_005A, 2'b00, 6'h0, 1'b1);
        end
        if (mq.size() > 0 || flush_wait > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: actual %0d entries left required 0", mq.size());
        end
        idle(1'b1);
        chk("final_count", bus.count, 0);
        chk("final_commit_valid", bus.commit_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
